// File: rtl/ldl_pkg.sv
// Shared types and sizing for the LDL job controller and its row/column counter.
package ldl_pkg;

  localparam int LDL_NUM_ROWS   = 4;
  localparam int LDL_WIDTH      = 32;
  localparam int ROW_ADDR_WIDTH = $clog2(LDL_NUM_ROWS);
  localparam int ROW_SIZE       = LDL_NUM_ROWS * LDL_WIDTH;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_START   = 4'd2,
    ST_RUN     = 4'd3,
    ST_OUT_D   = 4'd4,
    ST_RD_REQ  = 4'd5,
    ST_RD_WAIT = 4'd6,
    ST_OUT_ROW = 4'd7,
    ST_DONE    = 4'd8
  } ldl_job_state_t;

endpackage

// File: rtl/ldl_rc_counter.sv
// Row/column position counter: full (r,c) walk while loading, row-only walk during readout.
module ldl_rc_counter
  import ldl_pkg::*;
#(
  parameter int NUM_ROWS = LDL_NUM_ROWS,
  parameter int AW       = ROW_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          inc_i,
  input  logic          col_wrap_i,
  output logic [AW-1:0] r_o,
  output logic [AW-1:0] c_o,
  output logic          last_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ROWS - 1);

  logic [AW-1:0] r_q, r_d;
  logic [AW-1:0] c_q, c_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (clear_i) begin
      r_d = '0;
      c_d = '0;
    end else if (inc_i) begin
      if (col_wrap_i && (c_q != LAST_IDX)) begin
        c_d = c_q + AW'(1);
      end else begin
        c_d = '0;
        r_d = (r_q == LAST_IDX) ? '0 : r_q + AW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign r_o    = r_q;
  assign c_o    = c_q;
  assign last_o = (r_q == LAST_IDX) && (!col_wrap_i || (c_q == LAST_IDX));

endmodule

// File: rtl/ldl_job_controller.sv
// Sequences one LDL job: load matrix, run the decomposer, then stream out D and the matrix rows.
module ldl_job_controller
  import ldl_pkg::*;
#(
  parameter int NUM_ROWS = LDL_NUM_ROWS,
  parameter int WIDTH    = LDL_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_ROWS*WIDTH-1:0]     out_data,
  output logic                          out_is_d,
  output logic                          busy,
  output logic                          done,
  output logic                          dec_start,
  input  logic                          dec_finished,
  input  logic [NUM_ROWS*WIDTH-1:0]     d_out,
  input  logic [$clog2(NUM_ROWS)-1:0]   dec_row_addr,
  input  logic                          dec_row_addr_ready,
  input  logic [$clog2(NUM_ROWS)-1:0]   dec_write_row_addr,
  input  logic [$clog2(NUM_ROWS)-1:0]   dec_write_col_addr,
  input  logic [WIDTH-1:0]              dec_write_data,
  input  logic                          dec_write_ready,
  output logic [$clog2(NUM_ROWS)-1:0]   row_addr,
  output logic                          row_addr_ready,
  input  logic                          row_valid,
  input  logic [NUM_ROWS*WIDTH-1:0]     row_out,
  output logic [$clog2(NUM_ROWS)-1:0]   write_row_addr,
  output logic [$clog2(NUM_ROWS)-1:0]   write_col_addr,
  output logic [WIDTH-1:0]              write_data,
  output logic                          write_ready
);

  localparam int AW = $clog2(NUM_ROWS);
  localparam int RW = NUM_ROWS * WIDTH;

  ldl_job_state_t state_q, state_d;
  logic [RW-1:0]  row_q, row_d;

  logic          cnt_clear, cnt_inc, cnt_col_wrap, cnt_last;
  logic [AW-1:0] cnt_r, cnt_c;
  logic          dec_owns_ports;

  ldl_rc_counter #(
    .NUM_ROWS (NUM_ROWS),
    .AW       (AW)
  ) u_rc_counter (
    .clk        (clk),
    .rst_n      (rst),
    .clear_i    (cnt_clear),
    .inc_i      (cnt_inc),
    .col_wrap_i (cnt_col_wrap),
    .r_o        (cnt_r),
    .c_o        (cnt_c),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    cnt_col_wrap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          state_d   = ST_LOAD;
          cnt_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_col_wrap = 1'b1;
        if (in_valid) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_d = ST_START;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (dec_finished) state_d = ST_OUT_D;
      end
      ST_OUT_D: begin
        if (out_ready) begin
          state_d   = ST_RD_REQ;
          cnt_clear = 1'b1;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (row_valid) begin
          row_d   = row_out;
          state_d = ST_OUT_ROW;
        end
      end
      ST_OUT_ROW: begin
        if (out_ready) begin
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Decoded purely from registered state so a reset drops every strobe immediately.
  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dec_start = (state_q == ST_START);
  assign out_valid = (state_q == ST_OUT_D) || (state_q == ST_OUT_ROW);
  assign out_is_d  = (state_q == ST_OUT_D);
  assign out_data  = (state_q == ST_OUT_D)   ? d_out :
                     (state_q == ST_OUT_ROW) ? row_q : '0;

  // The decomposer owns the matrix ports only while it runs; its requests are dropped otherwise.
  assign dec_owns_ports = (state_q == ST_START) || (state_q == ST_RUN);

  assign row_addr       = dec_owns_ports ? dec_row_addr       : cnt_r;
  assign row_addr_ready = dec_owns_ports ? dec_row_addr_ready : (state_q == ST_RD_REQ);
  assign write_row_addr = dec_owns_ports ? dec_write_row_addr : cnt_r;
  assign write_col_addr = dec_owns_ports ? dec_write_col_addr : cnt_c;
  assign write_data     = dec_owns_ports ? dec_write_data     : in_data;
  assign write_ready    = dec_owns_ports ? dec_write_ready    : ((state_q == ST_LOAD) && in_valid);

endmodule

// File: tb/tb_ldl_job_controller.sv
// Bench for ldl_job_controller: matrix store model, decomposer stub driven inline, output scoreboard.
module tb_ldl_job_controller;
  import ldl_pkg::*;

  localparam int N  = LDL_NUM_ROWS;
  localparam int W  = LDL_WIDTH;
  localparam int AW = ROW_ADDR_WIDTH;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                job_start = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W-1:0]        in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ROW_SIZE-1:0] out_data;
  logic                out_is_d;
  logic                busy, done, dec_start;
  logic                dec_finished = 1'b0;
  logic [ROW_SIZE-1:0] d_out = '0;
  logic [AW-1:0]       dec_row_addr = '0;
  logic                dec_row_addr_ready = 1'b0;
  logic [AW-1:0]       dec_write_row_addr = '0;
  logic [AW-1:0]       dec_write_col_addr = '0;
  logic [W-1:0]        dec_write_data = '0;
  logic                dec_write_ready = 1'b0;
  logic [AW-1:0]       row_addr;
  logic                row_addr_ready;
  logic                row_valid = 1'b0;
  logic [ROW_SIZE-1:0] row_out = '0;
  logic [AW-1:0]       write_row_addr, write_col_addr;
  logic [W-1:0]        write_data;
  logic                write_ready;

  always #5 clk = ~clk;

  ldl_job_controller dut (
    .clk(clk), .rst(rst), .job_start(job_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_is_d(out_is_d),
    .busy(busy), .done(done), .dec_start(dec_start), .dec_finished(dec_finished), .d_out(d_out),
    .dec_row_addr(dec_row_addr), .dec_row_addr_ready(dec_row_addr_ready),
    .dec_write_row_addr(dec_write_row_addr), .dec_write_col_addr(dec_write_col_addr),
    .dec_write_data(dec_write_data), .dec_write_ready(dec_write_ready),
    .row_addr(row_addr), .row_addr_ready(row_addr_ready), .row_valid(row_valid), .row_out(row_out),
    .write_row_addr(write_row_addr), .write_col_addr(write_col_addr),
    .write_data(write_data), .write_ready(write_ready)
  );

  // Input matrix, the L factor the stub writes back, and the D vector it reports.
  logic [W-1:0] a_m [N][N];
  logic [W-1:0] l_m [N][N];
  logic [W-1:0] d_v [N];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [ROW_SIZE-1:0] pack_a_row(input int i);
    logic [ROW_SIZE-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = a_m[i][c];
    return v;
  endfunction

  function automatic logic [ROW_SIZE-1:0] exp_row(input int i);
    logic [ROW_SIZE-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = (c < i) ? l_m[i][c] : a_m[i][c];
    return v;
  endfunction

  function automatic logic [ROW_SIZE-1:0] pack_d();
    logic [ROW_SIZE-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = d_v[c];
    return v;
  endfunction

  // Scoreboard entries: {is_d, data}.
  logic [ROW_SIZE:0] sb [$];

  // out_ready pattern: always high, or high one cycle in four.
  int rdy_mode = 0;
  int ocyc     = 0;
  always @(posedge clk) begin
    #1;
    ocyc++;
    out_ready = (rdy_mode == 0) ? 1'b1 : ((ocyc % 4) == 0);
  end

  // Matrix store model plus protocol monitor, evaluated mid-cycle when everything is settled.
  logic [W-1:0]        mem [N][N];
  int                  wr_total = 0, done_total = 0, load_idx = 0, rd_cnt = 0;
  logic [AW-1:0]       rd_addr = '0;
  bit                  load_pend = 0, dec_start_prev = 0, stall_q = 0, held_is_d = 0;
  logic [ROW_SIZE-1:0] held_data = '0;
  logic [ROW_SIZE:0]   want;

  always @(negedge clk) begin
    row_valid = 1'b0;
    if (!rst) begin
      stall_q = 0; rd_cnt = 0; dec_start_prev = 0; load_pend = 0;
    end else begin
      if (load_pend) begin
        check("dec_start_after_load", dec_start, 1);
        load_pend = 0;
      end
      if (dec_start) check("dec_start_single", dec_start_prev, 0);
      dec_start_prev = dec_start;

      if (write_ready) begin
        wr_total++;
        if (!dec_write_ready) begin
          check("load_addr", {write_row_addr, write_col_addr},
                {AW'(load_idx / N), AW'(load_idx % N)});
          check("load_data", write_data, a_m[load_idx / N][load_idx % N]);
          load_idx = (load_idx + 1) % (N * N);
          if (load_idx == 0) load_pend = 1;
        end
        mem[write_row_addr][write_col_addr] = write_data;
      end

      if (stall_q) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_data);
        check("stall_is_d", out_is_d, held_is_d);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", sb.size(), 1);
        end else begin
          want = sb.pop_front();
          check("beat_is_d", out_is_d, want[ROW_SIZE]);
          check("beat_data", out_data, want[ROW_SIZE-1:0]);
        end
      end
      stall_q   = out_valid && !out_ready;
      held_data = out_data;
      held_is_d = out_is_d;
      if (done) done_total++;

      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          row_valid = 1'b1;
          for (int c = 0; c < N; c++) row_out[c*W +: W] = mem[rd_addr][c];
        end
      end
      if (row_addr_ready) begin
        rd_addr = row_addr;
        rd_cnt  = $urandom_range(1, 3);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One job: load, play the decomposer through the pass-through ports, then drain the outputs.
  task automatic run_job(input bit gap, input bit poke, input bit abort);
    int w0, d0, n;
    w0 = wr_total;
    d0 = done_total;
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    check("in_ready_load", in_ready, 1);
    for (int k = 0; k < N * N; k++) begin
      in_valid = 1'b1;
      in_data  = a_m[k / N][k % N];
      step();
      in_valid = 1'b0;
      if (gap && (k < N * N - 1)) begin
        step();
        step();
      end
    end
    check("dec_start_now", dec_start, 1);
    step();

    if (abort) begin
      rst = 1'b0;
      #1;
      check("rst_outputs", {in_ready, out_valid, out_is_d, busy, done, dec_start,
                            row_addr_ready, write_ready}, 0);
      step();
      rst = 1'b1;
      step();
      check("abort_writes", wr_total - w0, N * N);
      check("abort_done", done_total - d0, 0);
      return;
    end

    if (poke) begin
      job_start = 1'b1;
      step();
      job_start = 1'b0;
      check("busy_poke", busy, 1);
    end

    for (int k = 0; k < N; k += N - 1) begin
      dec_row_addr       = AW'(k);
      dec_row_addr_ready = 1'b1;
      #1;
      check("pt_row_req", {row_addr_ready, row_addr}, {1'b1, AW'(k)});
      step();
      dec_row_addr_ready = 1'b0;
      n = 0;
      while (!row_valid && n < 20) begin
        step();
        n++;
      end
      check("pt_row_valid", row_valid, 1);
      check("pt_row_data", row_out, pack_a_row(k));
    end

    for (int i = 1; i < N; i++) begin
      for (int j = 0; j < i; j++) begin
        dec_write_row_addr = AW'(i);
        dec_write_col_addr = AW'(j);
        dec_write_data     = l_m[i][j];
        dec_write_ready    = 1'b1;
        step();
        dec_write_ready    = 1'b0;
      end
    end

    sb.push_back({1'b1, pack_d()});
    for (int i = 0; i < N; i++) sb.push_back({1'b0, exp_row(i)});
    d_out        = pack_d();
    dec_finished = 1'b1;
    step();
    dec_finished = 1'b0;
    if (poke) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
    end

    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    check("job_end_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
    check("job_writes", wr_total - w0, N * N + N * (N - 1) / 2);
    check("job_done", done_total - d0, 1);
    step();
    step();
    check("idle_after_job", {busy, in_ready, out_valid}, 0);
  endtask

  initial begin
    a_m = '{'{32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000},
            '{32'hBF80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h4000_0000},
            '{32'h3F80_0000, 32'hBF80_0000, 32'h40A0_0000, 32'h4000_0000},
            '{32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 32'h40C0_0000}};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) l_m[i][j] = '0;
    l_m[1][0] = 32'hBF80_0000;
    l_m[2][0] = 32'h3F80_0000;
    l_m[2][1] = 32'h0000_0000;
    l_m[3][0] = 32'h0000_0000;
    l_m[3][1] = 32'h4000_0000;
    l_m[3][2] = 32'h3F00_0000;
    d_v = '{32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3F80_0000};

    #1 rst = 1'b0;
    step();
    step();
    check("reset_outputs", {in_ready, out_valid, out_is_d, busy, done, dec_start,
                            row_addr_ready, write_ready}, 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b1;
    step();

    dec_write_ready    = 1'b1;
    dec_row_addr_ready = 1'b1;
    dec_finished       = 1'b1;
    #1;
    check("idle_write_ready", write_ready, 0);
    check("idle_row_req", row_addr_ready, 0);
    step();
    step();
    check("idle_ignores_dec", {busy, write_ready, row_addr_ready}, 0);
    dec_write_ready    = 1'b0;
    dec_row_addr_ready = 1'b0;
    dec_finished       = 1'b0;
    step();

    rdy_mode = 0; run_job(1'b0, 1'b0, 1'b0);
    rdy_mode = 1; run_job(1'b1, 1'b0, 1'b0);
    rdy_mode = 0; run_job(1'b0, 1'b1, 1'b0);
    run_job(1'b0, 1'b0, 1'b1);
    run_job(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
